// File: rtl/unary_stream_gen.sv
// rtl/unary_stream_gen.sv - binary-to-unary stream sequencer and unary-to-binary decoder for one unary adder
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready   operand handshake; in_ready is high only while idle
//   a_val, b_val         binary operands, saturated to LEN when latched
//   A, B                 thermometer-coded operand streams to the adder
//   en, read_or_write    adder controls (read_or_write: 0 = adder reads A/B, 1 = adder writes dout)
//   dout, C              unary result stream and carry/overflow flag from the adder
//   sum, ovf, sum_valid  decoded result, overflow seen, one-cycle update strobe
module unary_stream_gen #(
  parameter int CNT_W  = 4,
  parameter int LEN    = 15,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] a_val,
  input  logic [CNT_W-1:0] b_val,
  output logic             A,
  output logic             B,
  output logic             en,
  output logic             read_or_write,
  input  logic             dout,
  input  logic             C,
  output logic [CNT_W:0]   sum,
  output logic             ovf,
  output logic             sum_valid
);

  // One position counter serves both the SEND and COLLECT phases.
  localparam int COLL_LEN = RD_LAT + 2 * LEN;
  localparam int POS_W    = $clog2(COLL_LEN + 1);
  localparam int CMP_W    = (POS_W > CNT_W) ? POS_W : CNT_W;

  localparam logic [POS_W-1:0] SEND_LAST = POS_W'(LEN - 1);
  localparam logic [POS_W-1:0] COLL_LAST = POS_W'(COLL_LEN - 1);
  localparam logic [POS_W-1:0] RD_START  = POS_W'(RD_LAT);
  localparam logic [CNT_W-1:0] LEN_VAL   = CNT_W'(LEN);
  localparam logic [CNT_W:0]   CNT_MAX   = (CNT_W + 1)'(2 * LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [POS_W-1:0] pos, pos_nxt;
  logic [CNT_W-1:0] a_sat, a_sat_nxt;
  logic [CNT_W-1:0] b_sat, b_sat_nxt;
  logic [CNT_W:0]   count, count_nxt;
  logic             flag, flag_nxt;

  logic             a_nxt, b_nxt, en_nxt, rw_nxt, sum_valid_nxt, ovf_nxt;
  logic [CNT_W:0]   sum_nxt;

  assign in_ready = (state == S_IDLE);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pos           <= '0;
      a_sat         <= '0;
      b_sat         <= '0;
      count         <= '0;
      flag          <= 1'b0;
      A             <= 1'b0;
      B             <= 1'b0;
      en            <= 1'b0;
      read_or_write <= 1'b0;
      sum           <= '0;
      ovf           <= 1'b0;
      sum_valid     <= 1'b0;
    end else begin
      state         <= state_nxt;
      pos           <= pos_nxt;
      a_sat         <= a_sat_nxt;
      b_sat         <= b_sat_nxt;
      count         <= count_nxt;
      flag          <= flag_nxt;
      A             <= a_nxt;
      B             <= b_nxt;
      en            <= en_nxt;
      read_or_write <= rw_nxt;
      sum           <= sum_nxt;
      ovf           <= ovf_nxt;
      sum_valid     <= sum_valid_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    a_sat_nxt = a_sat;
    b_sat_nxt = b_sat;
    count_nxt = count;
    flag_nxt  = flag;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt = S_SEND;
          pos_nxt   = '0;
          a_sat_nxt = (a_val > LEN_VAL) ? LEN_VAL : a_val;
          b_sat_nxt = (b_val > LEN_VAL) ? LEN_VAL : b_val;
          count_nxt = '0;
          flag_nxt  = 1'b0;
        end
      end
      S_SEND: begin
        if (pos == SEND_LAST) begin
          state_nxt = S_COLLECT;
          pos_nxt   = '0;
        end else begin
          pos_nxt = pos + POS_W'(1);
        end
      end
      S_COLLECT: begin
        // dout is meaningless for the first RD_LAT cycles of write mode
        if ((pos >= RD_START) && dout && (count != CNT_MAX)) begin
          count_nxt = count + (CNT_W + 1)'(1);
        end
        if (C) begin
          flag_nxt = 1'b1;
        end
        if (pos == COLL_LAST) begin
          state_nxt = S_DONE;
          pos_nxt   = '0;
        end else begin
          pos_nxt = pos + POS_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: computed from the next state so that every output is a
  // flop yet lines up with the cycle its state is active in. The result is
  // captured from count_nxt so the final COLLECT sample is included.
  always_comb begin
    a_nxt         = (state_nxt == S_SEND) && (CMP_W'(pos_nxt) < CMP_W'(a_sat_nxt));
    b_nxt         = (state_nxt == S_SEND) && (CMP_W'(pos_nxt) < CMP_W'(b_sat_nxt));
    en_nxt        = (state_nxt == S_SEND) || (state_nxt == S_COLLECT);
    rw_nxt        = (state_nxt == S_COLLECT);
    sum_valid_nxt = (state_nxt == S_DONE);
    sum_nxt       = sum;
    ovf_nxt       = ovf;
    if (state_nxt == S_DONE) begin
      sum_nxt = count_nxt;
      ovf_nxt = flag_nxt;
    end
  end

endmodule

// File: tb/tb_unary_stream_gen.sv
// tb/tb_unary_stream_gen.sv - directed self-checking bench for unary_stream_gen
module tb_unary_stream_gen;

  localparam int CNT_W  = 4;
  localparam int LEN    = 15;
  localparam int RD_LAT = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] a_val;
  logic [CNT_W-1:0] b_val;
  logic             A;
  logic             B;
  logic             en;
  logic             read_or_write;
  logic             dout = 1'b0;
  logic             C = 1'b0;
  logic [CNT_W:0]   sum;
  logic             ovf;
  logic             sum_valid;

  int n_assert = 0;
  int n_fail   = 0;

  // adder model settings
  int m_ones  = 0;
  bit m_c     = 1'b0;
  bit m_junk  = 1'b0;
  int mj      = 0;

  logic [CNT_W:0] last_sum = '0;
  logic           last_ovf = 1'b0;

  unary_stream_gen #(.CNT_W(CNT_W), .LEN(LEN), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_val(a_val), .b_val(b_val), .A(A), .B(B), .en(en),
    .read_or_write(read_or_write), .dout(dout), .C(C),
    .sum(sum), .ovf(ovf), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  // Adder model: in write mode, after RD_LAT cycles, return m_ones ones then
  // zeros; C marks the last one when m_c is set. m_junk drives garbage ones
  // during the latency window, which must be ignored.
  always @(negedge clk) begin
    if (read_or_write === 1'b1) begin
      if (mj < RD_LAT) begin
        dout = m_junk;
        C    = 1'b0;
      end else begin
        dout = ((mj - RD_LAT) < m_ones);
        C    = m_c && ((mj - RD_LAT) == (m_ones - 1));
      end
      mj = mj + 1;
    end else begin
      mj   = 0;
      dout = 1'b0;
      C    = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input int a, input int b, input int ones, input bit c_last,
                       input bit junk, input bit hold, input bit noise,
                       input logic [LEN-1:0] ea, input logic [LEN-1:0] eb,
                       input int esum, input bit eovf);
    logic [LEN-1:0] sa;
    logic [LEN-1:0] sb;
    bit send_ok;
    bit coll_ok;
    sa = '0;
    sb = '0;
    send_ok = 1'b1;
    coll_ok = 1'b1;
    @(negedge clk);
    m_ones   = ones;
    m_c      = c_last;
    m_junk   = junk;
    a_val    = CNT_W'(a);
    b_val    = CNT_W'(b);
    in_valid = 1'b1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("result_held", 32'({sum, ovf}), 32'({last_sum, last_ovf}));
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      if (!hold) in_valid = noise ? i[0] : 1'b0;
      if (noise) begin
        a_val = CNT_W'($urandom_range(0, 15));
        b_val = CNT_W'($urandom_range(0, 15));
      end
      sa[i] = A;
      sb[i] = B;
      if (!(en === 1'b1 && read_or_write === 1'b0 && in_ready === 1'b0 && sum_valid === 1'b0))
        send_ok = 1'b0;
    end
    check("send_A", 32'(sa), 32'(ea));
    check("send_B", 32'(sb), 32'(eb));
    check("send_ctrl", 32'(send_ok), 32'd1);
    for (int j = 0; j < RD_LAT + 2 * LEN; j++) begin
      @(negedge clk);
      if (!hold) in_valid = noise ? ~j[0] : 1'b0;
      if (noise) a_val = CNT_W'($urandom_range(0, 15));
      if (!(en === 1'b1 && read_or_write === 1'b1 && A === 1'b0 && B === 1'b0 &&
            in_ready === 1'b0 && sum_valid === 1'b0))
        coll_ok = 1'b0;
    end
    check("collect_ctrl", 32'(coll_ok), 32'd1);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    check("done_sum_valid", 32'(sum_valid), 32'd1);
    check("done_ctrl", 32'({en, read_or_write, in_ready, A, B}), 32'd0);
    check("done_sum", 32'(sum), 32'(esum));
    check("done_ovf", 32'(ovf), 32'(eovf));
    last_sum = (CNT_W + 1)'(esum);
    last_ovf = eovf;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a_val    = '0;
    b_val    = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_en", 32'(en), 32'd0);
    check("rst_rw", 32'(read_or_write), 32'd0);
    check("rst_AB", 32'({A, B}), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    rst = 1'b0;

    // basic sum, with garbage on dout during the read latency
    frame(3, 5, 8, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0007, 15'h001F, 8, 1'b0);
    // saturation with overflow on the last one
    frame(15, 15, 30, 1'b1, 1'b0, 1'b0, 1'b0, 15'h7FFF, 15'h7FFF, 30, 1'b1);
    // zero operands; overflow flag must clear for the new frame
    frame(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0000, 15'h0000, 0, 1'b0);
    // back-to-back with in_valid held high
    frame(2, 4, 6, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0003, 15'h000F, 6, 1'b0);
    frame(7, 1, 8, 1'b0, 1'b0, 1'b0, 1'b0, 15'h007F, 15'h0001, 8, 1'b0);
    // in_valid toggling and operands changing mid-frame
    frame(6, 9, 15, 1'b0, 1'b0, 1'b0, 1'b1, 15'h003F, 15'h01FF, 15, 1'b0);

    // reset during SEND cycle 5
    @(negedge clk);
    a_val    = 4'd9;
    b_val    = 4'd6;
    in_valid = 1'b1;
    m_ones   = 15;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_pre_en", 32'({en, A, B}), 32'b111);
    #1 rst = 1'b1;
    #1;
    check("abort_en", 32'(en), 32'd0);
    check("abort_AB", 32'({A, B}), 32'd0);
    check("abort_rw", 32'(read_or_write), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_sum", 32'({sum, ovf}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      bit quiet;
      quiet = 1'b1;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (sum_valid !== 1'b0 || en !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
      end
      check("abort_no_sum_valid", 32'(quiet), 32'd1);
    end
    last_sum = '0;
    last_ovf = 1'b0;
    frame(1, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0001, 15'h0001, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
